// File: rtl/block_plotter.sv
// block_plotter
//   Latches one block position/colour on an accepted start strobe.
//   It then sweeps the BLOCK_W x BLOCK_H footprint in raster order and issues
//   one VGA-adapter pixel slot per clock. Pixels that fall off screen keep
//   their slot, but with plot=0. A one-cycle done pulse follows the last slot.
//
//   Optional build macro: BLOCK_PLOTTER_OUTLINE_EN
//     When defined, edge pixels of the footprint are drawn black (3'b000).
//     Interior pixels keep the latched colour.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   start       draw request, accepted only while ready=1
//   x_in/y_in   block top-left column/row
//   colour_in   block colour (3'b000 = erase)
//   ready       high in IDLE (combinational)
//   vga_x/vga_y pixel coordinate to the VGA adapter (registered)
//   vga_colour  pixel colour to the VGA adapter (registered)
//   plot        VGA writeEn (registered)
//   done        one-cycle pulse after the last pixel slot (registered)
module block_plotter #(
  parameter int BLOCK_W  = 4,
  parameter int BLOCK_H  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic       ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done
);

  localparam int OXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int OYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
  localparam logic [OXW-1:0] OX_LAST = OXW'(BLOCK_W - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(BLOCK_H - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [7:0]     base_x;
  logic [6:0]     base_y;
  logic [2:0]     base_col;
  logic [OXW-1:0] off_x;
  logic [OYW-1:0] off_y;

  // Offsets of the slot currently on the outputs; the next slot is computed
  // from them, so the output registers always hold the slot being shown.
  logic           last_x, last_y;
  logic [OXW-1:0] nxt_ox, src_ox;
  logic [OYW-1:0] nxt_oy, src_oy;
  logic [7:0]     src_x;
  logic [6:0]     src_y;
  logic [2:0]     src_col, pix_col;
  logic [8:0]     sum_x;
  logic [7:0]     sum_y;
  logic           pix_on;

  assign ready = (state == S_IDLE);

  always_comb begin
    last_x = (off_x == OX_LAST);
    last_y = (off_y == OY_LAST);
    nxt_ox = last_x ? '0 : off_x + OXW'(1);
    nxt_oy = last_x ? off_y + OYW'(1) : off_y;

    // In IDLE the first slot is formed straight from the inputs so that the
    // first plot appears in the cycle right after acceptance.
    if (state == S_IDLE) begin
      src_x   = x_in;
      src_y   = y_in;
      src_col = colour_in;
      src_ox  = '0;
      src_oy  = '0;
    end else begin
      src_x   = base_x;
      src_y   = base_y;
      src_col = base_col;
      src_ox  = nxt_ox;
      src_oy  = nxt_oy;
    end

    // Wide sums so blocks near the right/bottom edge clip instead of wrapping.
    sum_x  = {1'b0, src_x} + {{(9-OXW){1'b0}}, src_ox};
    sum_y  = {1'b0, src_y} + {{(8-OYW){1'b0}}, src_oy};
    pix_on = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

`ifdef BLOCK_PLOTTER_OUTLINE_EN
    if (src_ox == '0 || src_ox == OX_LAST || src_oy == '0 || src_oy == OY_LAST)
      pix_col = 3'b000;
    else
      pix_col = src_col;
`else
    pix_col = src_col;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      base_x     <= '0;
      base_y     <= '0;
      base_col   <= '0;
      off_x      <= '0;
      off_y      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            base_x     <= x_in;
            base_y     <= y_in;
            base_col   <= colour_in;
            off_x      <= '0;
            off_y      <= '0;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= pix_col;
            plot       <= pix_on;
            state      <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_x && last_y) begin
            plot  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            off_x      <= nxt_ox;
            off_y      <= nxt_oy;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= pix_col;
            plot       <= pix_on;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
